// File: rtl/pu3_ctrl.sv
// Sequencer for one PU3 inference: clears the MAC accumulators, streams N_IN
// feature/weight addresses, drains the read and MAC pipelines, then holds results until taken.
module pu3_ctrl #(
   parameter int N_IN    = 32,
   parameter int AW      = 5,
   parameter int RD_LAT  = 1,
   parameter int MAC_LAT = 2
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          start_i,
   output logic          rd_en_o,
   output logic [AW-1:0] addr_o,
   output logic          mac_en_o,
   output logic          valid_o,
   output logic          mac_clear_o,
   output logic          busy_o,
   output logic          res_valid_o,
   input  logic          res_ready_i
);

   localparam int DRAIN_CYC = RD_LAT + MAC_LAT;
   localparam int DW        = $clog2(DRAIN_CYC + 1);
   localparam logic [AW-1:0] FEED_LAST  = AW'(N_IN - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       feed_cnt_q, feed_cnt_d;
   logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
   logic [RD_LAT-1:0]   valid_sr_q, valid_sr_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         feed_cnt_q  <= '0;
         drain_cnt_q <= '0;
         valid_sr_q  <= '0;
      end else begin
         state_q     <= state_d;
         feed_cnt_q  <= feed_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         valid_sr_q  <= valid_sr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      feed_cnt_d  = feed_cnt_q;
      drain_cnt_d = drain_cnt_q;
      rd_en_o     = 1'b0;
      addr_o      = '0;
      mac_en_o    = 1'b0;
      mac_clear_o = 1'b0;
      res_valid_o = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            mac_clear_o = 1'b1;
            mac_en_o    = 1'b1;
            feed_cnt_d  = '0;
            state_d     = FEED;
         end
         FEED: begin
            rd_en_o  = 1'b1;
            mac_en_o = 1'b1;
            addr_o   = feed_cnt_q;
            if (feed_cnt_q == FEED_LAST) begin
               drain_cnt_d = '0;
               state_d     = DRAIN;
            end else begin
               feed_cnt_d = feed_cnt_q + AW'(1);
            end
         end
         DRAIN: begin
            mac_en_o = 1'b1;
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + DW'(1);
            end
         end
         DONE: begin
            res_valid_o = 1'b1;
            if (res_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // valid_o tracks rd_en_o through a fixed RD_LAT-deep delay line
   always_comb begin
      valid_sr_d    = '0;
      valid_sr_d[0] = rd_en_o;
      for (int i = 1; i < RD_LAT; i++) begin
         valid_sr_d[i] = valid_sr_q[i-1];
      end
   end

   assign valid_o = valid_sr_q[RD_LAT-1];
   assign busy_o  = (state_q != IDLE);

endmodule

// File: doc/pu3_ctrl.md
PU3_CTRL -- requirements
Module: pu3_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  N_IN, 32, input features accumulated per inference
  AW, 5, feature/weight address width, with 2^AW >= N_IN
  RD_LAT, 1, feature-buffer/weight-ROM read latency in cycles (>=1)
  MAC_LAT, 2, cycles from last MAC valid to the MAC outputs being stable (>=1)
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk_i  in  1  single clock; all logic on rising edge
  rstn_i  in  1  asynchronous active-low reset
  start_i  in  1  launch one inference; sampled only in IDLE
  rd_en_o  out  1  read strobe to feature buffer and weight ROM
  addr_o  out  AW  feature index; the same address drives the weight ROM
  mac_en_o  out  1  MAC array enable
  valid_o  out  1  MAC data-valid; aligned with returned read data
  mac_clear_o  out  1  one-cycle accumulator clear
  busy_o  out  1  high in every state except IDLE
  res_valid_o  out  1  MAC array outputs are final
  res_ready_i  in  1  consumer has taken the results

Function
REQ-003 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-004 IDLE: start_i=1 moves to CLEAR next cycle; otherwise the FSM stays in IDLE.
REQ-005 CLEAR: lasts exactly 1 cycle with mac_clear_o=1, mac_en_o=1, rd_en_o=0, then FEED.
REQ-006 FEED: lasts exactly N_IN cycles with rd_en_o=1, mac_en_o=1; addr_o=0 on the first cycle, +1 per cycle, N_IN-1 on the last; then DRAIN.
REQ-007 addr_o SHALL hold 0 outside FEED; no wrap beyond N_IN-1; N_IN=1 gives one FEED cycle at address 0.
REQ-008 valid_o SHALL equal rd_en_o delayed by exactly RD_LAT cycles through a shift register cleared by reset.
REQ-009 DRAIN: lasts exactly RD_LAT+MAC_LAT cycles with mac_en_o=1, rd_en_o=0; then DONE.
REQ-010 The last valid_o pulse SHALL occur within DRAIN, RD_LAT cycles after the last FEED cycle.
REQ-011 valid_o SHALL be high for exactly N_IN cycles per inference.
REQ-012 DONE: res_valid_o=1 and mac_en_o=0; the MAC outputs hold their values.
REQ-013 DONE SHALL stay until res_ready_i=1, then return to IDLE next cycle with res_valid_o=0.
REQ-014 res_ready_i outside DONE SHALL be ignored.
REQ-015 start_i outside IDLE SHALL be ignored and never queued.
REQ-016 start_i=1 together with res_ready_i=1 in DONE completes the handshake only; a new start requires start_i high while in IDLE.
REQ-017 mac_clear_o SHALL pulse exactly once per inference, always before the first valid_o.
REQ-018 Latency from start_i sampled to res_valid_o rising SHALL be 1+N_IN+RD_LAT+MAC_LAT+1 cycles (37 with defaults).
REQ-019 The FEED counter SHALL be AW bits wide; the DRAIN counter SHALL be wide enough for RD_LAT+MAC_LAT.

Reset
REQ-020 rstn_i low SHALL immediately force IDLE and clear the counters and the valid shift register.
REQ-021 While rstn_i is low, every output SHALL be 0: rd_en_o, addr_o, mac_en_o, valid_o, mac_clear_o, busy_o, res_valid_o.
REQ-022 Reset asserted mid-inference SHALL abandon it with no residual valid_o or res_valid_o after release.
REQ-023 After reset release, the FSM SHALL wait in IDLE for start_i.

Verification
REQ-024 Defaults, single start pulse:
  -> mac_clear_o at cycle 1
  -> rd_en_o cycles 2..33, addr 0..31
  -> valid_o cycles 3..34
  -> res_valid_o at cycle 37
  -> res_ready_i=1 -> busy_o=0 next cycle
REQ-025 start_i held high throughout the inference:
  -> exactly one mac_clear_o pulse and 32 valid_o pulses before DONE
  -> no restart until the FSM returns to IDLE
REQ-026 res_ready_i held low for 10 cycles in DONE:
  -> res_valid_o stays 1 and mac_en_o stays 0 for all 10 cycles
  -> ready pulse -> IDLE
REQ-027 rstn_i low at FEED address 15:
  -> all outputs 0 asynchronously
  -> after release, no valid_o until a new start_i
REQ-028 N_IN=1, RD_LAT=2, MAC_LAT=1:
  -> one rd_en_o at addr 0
  -> valid_o two cycles later
  -> res_valid_o 6 cycles after start
REQ-029 start_i and res_ready_i both high in DONE:
  -> return to IDLE
  -> no CLEAR until start_i is sampled in IDLE
